// File: rtl/mux4.sv
// +--------------------------------------------------------------------------+
// | mux4 : registered N_IN-lane, DATA_W-bit select with range-error flag     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mux4 #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 1,
  parameter int SEL_W  = $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN*DATA_W-1:0]   a,
  input  logic [SEL_W-1:0]         s,
  output logic [DATA_W-1:0]        o,
  output logic                     o_valid,
  output logic                     sel_err
);

  localparam logic [SEL_W:0] c_N_IN = (SEL_W+1)'(N_IN);

  if ((N_IN < 2) || (N_IN > 16) || (DATA_W < 1) || (SEL_W < $clog2(N_IN))) begin : g_param_err
    $error("mux4: illegal parameters N_IN=%0d DATA_W=%0d SEL_W=%0d", N_IN, DATA_W, SEL_W);
  end

  logic [N_IN-1:0]   w_hit;
  logic [DATA_W-1:0] w_sel;
  logic              w_range_err;

  // One-hot decode feeding an AND-OR tree keeps the selection flat and priority-free.
  for (genvar k = 0; k < N_IN; k++) begin : g_dec
    assign w_hit[k] = (s == SEL_W'(k));
  end

  assign w_range_err = ({1'b0, s} >= c_N_IN);

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_IN; k++) begin
      w_sel = w_sel | (a[k*DATA_W +: DATA_W] & {DATA_W{w_hit[k]}});
    end
  end

  logic [DATA_W-1:0] o_d, o_q;
  logic              valid_d, valid_q;
  logic              err_d, err_q;

  always_comb begin
    o_d     = w_range_err ? '0 : w_sel;
    err_d   = w_range_err;
    valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      o_q     <= o_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o       = o_q;
  assign o_valid = valid_q;
  assign sel_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mux4.sv
// +--------------------------------------------------------------------------+
// | tb_mux4 : vector tables, async-reset sequence and randomized model check |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mux4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a4;
  logic [1:0]  s4;
  logic        o4;
  logic        v4;
  logic        e4;
  logic [23:0] a3;
  logic [1:0]  s3;
  logic [7:0]  o3;
  logic        v3;
  logic        e3;

  int total = 0;
  int bad   = 0;

  mux4 u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a4),
    .s       (s4),
    .o       (o4),
    .o_valid (v4),
    .sel_err (e4)
  );

  mux4 #(.N_IN(3), .DATA_W(8)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a3),
    .s       (s3),
    .o       (o3),
    .o_valid (v3),
    .sel_err (e3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [1:0] s;
    logic       exp_o;
  } vec4_t;

  typedef struct {
    logic [23:0] a;
    logic [1:0]  s;
    logic [7:0]  exp_o;
    logic        exp_err;
  } vec3_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: lane index k lives at bits k*W..k*W+W-1; out-of-range select yields zero.
  function automatic logic [31:0] ref_lane(input logic [31:0] av, input int sel, input int n, input int w);
    logic [31:0] mask;
    mask = (32'h1 << w) - 32'h1;
    if (sel >= n) return 32'h0;
    return (av >> (sel * w)) & mask;
  endfunction

  vec4_t t4[12];
  vec3_t t3[6];

  initial begin
    t4[0]  = '{4'b0101, 2'd0, 1'b1};
    t4[1]  = '{4'b0101, 2'd1, 1'b0};
    t4[2]  = '{4'b0101, 2'd2, 1'b1};
    t4[3]  = '{4'b0101, 2'd3, 1'b0};
    t4[4]  = '{4'b0000, 2'd2, 1'b0};
    t4[5]  = '{4'b0100, 2'd2, 1'b1};
    t4[6]  = '{4'b1011, 2'd2, 1'b0};
    t4[7]  = '{4'b1001, 2'd0, 1'b1};
    t4[8]  = '{4'b1001, 2'd3, 1'b1};
    t4[9]  = '{4'b1001, 2'd0, 1'b1};
    t4[10] = '{4'b1001, 2'd3, 1'b1};
    t4[11] = '{4'b1001, 2'd0, 1'b1};

    t3[0] = '{24'hC35A11, 2'd0, 8'h11, 1'b0};
    t3[1] = '{24'hC35A11, 2'd1, 8'h5A, 1'b0};
    t3[2] = '{24'hC35A11, 2'd2, 8'hC3, 1'b0};
    t3[3] = '{24'hC35A11, 2'd3, 8'h00, 1'b1};
    t3[4] = '{24'hC35A11, 2'd1, 8'h5A, 1'b0};
    t3[5] = '{24'hC35A11, 2'd3, 8'h00, 1'b1};

    rst_n = 1'b0;
    a4 = 4'b0101; s4 = 2'd0;
    a3 = 24'hC35A11; s3 = 2'd0;
    step();
    step();
    chk("rst_o4", {31'b0, o4}, 32'h0);
    chk("rst_v4", {31'b0, v4}, 32'h0);
    chk("rst_e4", {31'b0, e4}, 32'h0);
    chk("rst_o3", {24'b0, o3}, 32'h0);
    chk("rst_v3", {31'b0, v3}, 32'h0);

    rst_n = 1'b1;
    step();
    chk("rel_o4", {31'b0, o4}, 32'h1);
    chk("rel_v4", {31'b0, v4}, 32'h1);
    chk("rel_o3", {24'b0, o3}, 32'h11);

    for (int i = 0; i < 12; i++) begin
      a4 = t4[i].a;
      s4 = t4[i].s;
      step();
      chk($sformatf("t4_o[%0d]", i), {31'b0, o4}, {31'b0, t4[i].exp_o});
      chk($sformatf("t4_err[%0d]", i), {31'b0, e4}, 32'h0);
    end

    for (int i = 0; i < 6; i++) begin
      a3 = t3[i].a;
      s3 = t3[i].s;
      step();
      chk($sformatf("t3_o[%0d]", i), {24'b0, o3}, {24'b0, t3[i].exp_o});
      chk($sformatf("t3_err[%0d]", i), {31'b0, e3}, {31'b0, t3[i].exp_err});
    end

    // Asynchronous reset pulsed between edges while err and o are both set.
    a4 = 4'b0101; s4 = 2'd0;
    a3 = 24'hC35A11; s3 = 2'd3;
    step();
    chk("pre_o4", {31'b0, o4}, 32'h1);
    chk("pre_e3", {31'b0, e3}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_o4", {31'b0, o4}, 32'h0);
    chk("async_v4", {31'b0, v4}, 32'h0);
    chk("async_e3", {31'b0, e3}, 32'h0);
    chk("async_v3", {31'b0, v3}, 32'h0);
    s4 = 2'd2;
    s3 = 2'd1;
    #2 rst_n = 1'b1;
    step();
    chk("post_o4", {31'b0, o4}, 32'h1);
    chk("post_v4", {31'b0, v4}, 32'h1);
    chk("post_o3", {24'b0, o3}, 32'h5A);
    chk("post_e3", {31'b0, e3}, 32'h0);

    for (int i = 0; i < 200; i++) begin
      a4 = 4'($urandom);
      s4 = 2'($urandom_range(0, 3));
      a3 = 24'($urandom);
      s3 = 2'($urandom_range(0, 3));
      step();
      chk("rnd_o4", {31'b0, o4}, ref_lane({28'b0, a4}, int'(s4), 4, 1));
      chk("rnd_e4", {31'b0, e4}, 32'h0);
      chk("rnd_o3", {24'b0, o3}, ref_lane({8'b0, a3}, int'(s3), 3, 8));
      chk("rnd_e3", {31'b0, e3}, (int'(s3) >= 3) ? 32'h1 : 32'h0);
      chk("rnd_v", {30'b0, v4, v3}, 32'h3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
